mc_controlunit: RTL and testbench
=================================

Name: mc_controlunit

Overview:
- Multicycle successor to the single-cycle MIPS control unit.
- Moore FSM that sequences each instruction over 3–5 cycles and drives datapath mux selects, write strobes and ALU control.
- Adds parameter-gated optional instructions (addi, j, bne), illegal-instruction detection and a retired-instruction counter.
- Sits between the instruction register (opcode/funct) and the shared-memory multicycle datapath.

Parameters:
- ENABLE_ADDI, 1, decode opcode 001000 (addi); 0 treats it as illegal.
- ENABLE_JUMP, 1, decode opcode 000010 (j); 0 treats it as illegal.
- ENABLE_BNE, 0, decode opcode 000101 (bne); 0 treats it as illegal.
- CNT_W, 32, width of instret counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26], sampled from the IR
- funct  in  6  instr[5:0]
- Zero  in  1  ALU zero flag
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select: 1=rd, 0=rt
- MemtoReg  out  1  register write data: 1=Data reg, 0=ALUOut
- RegWrite  out  1  register file write strobe
- ALUSrcA  out  1  ALU A select: 0=PC, 1=register A
- ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- PCSrc  out  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
- PCEn  out  1  PC load enable
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_instr  out  1  one-cycle pulse on an undecodable instruction
- instret  out  CNT_W  count of retired instructions

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Reset (asynchronous):
  - state=FETCH, instret=0, illegal_instr=0.
  - While reset is high, MemWrite, IRWrite, RegWrite and PCEn are forced to 0.
  - Reset mid-instruction abandons the instruction; no strobe fires and instret is not incremented.
- Outputs are decoded from the current state only, except:
  - PCEn = PCWrite | (Branch & (Zero XOR isBne)).
  - alucontrol in EXECUTE is decoded from funct.
  - Any output not listed for a state is 0.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, alucontrol=010, PCSrc=00, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, alucontrol=010 (branch target computed into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) with funct in {100000, 100010, 100100, 100101, 101010} -> EXECUTE.
  - 000100 (beq) -> BRANCH.
  - 000101 (bne) -> BRANCH if ENABLE_BNE=1.
  - 001000 (addi) -> ADDIEX if ENABLE_ADDI=1.
  - 000010 (j) -> JUMP if ENABLE_JUMP=1.
  - Anything else, including a disabled opcode or an unsupported funct -> FETCH; illegal_instr is registered high for exactly the next cycle; instret unchanged.
- MEMADR: ALUSrcA=1, ALUSrcB=10, alucontrol=010. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Next: MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
- MEMWR: IorD=1, MemWrite=1. Next: FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, alucontrol from funct (100000->010, 100010->110, 100100->000, 100101->001, 101010->111). Next: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, alucontrol=110, PCSrc=01, Branch=1.
  - isBne=1 when opcode=000101: PCEn = ~Zero for bne, Zero for beq.
  - Next: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, alucontrol=010. Next: ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next: FETCH.
- Latency in cycles including FETCH: lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3; illegal 2.
- instret:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. Does not increment from DECODE (illegal).
  - Wraps modulo 2^CNT_W with no saturation.
- opcode and funct are held stable by the IR from DECODE until the return to FETCH; the block does not latch them.
- Unreachable state encodings -> FETCH next cycle, all strobes 0.

Test Plan:
- Reset asserted mid-MEMRD of lw (opcode 100011) -> outputs immediately FETCH-decoded with strobes 0, instret=0; after release, FETCH asserts IRWrite=1, PCEn=1, ALUSrcB=01.
- lw then sw back-to-back -> lw states FETCH, DECODE, MEMADR, MEMRD, MEMWB (RegWrite=1, MemtoReg=1); sw has MemWrite=1 only in MEMWR; instret=2.
- R-type over each funct 100000/100010/100100/100101/101010 -> EXECUTE alucontrol=010/110/000/001/111, ALUWB RegDst=1; funct 000000 -> illegal_instr one-cycle pulse, instret unchanged.
- beq with Zero=1 -> PCEn=1, PCSrc=01 in BRANCH; with Zero=0 -> PCEn=0; ENABLE_BNE=1 bne with Zero=0 -> PCEn=1.
- Default parameters, opcode 000101 -> illegal_instr=1 for one cycle after DECODE, back to FETCH; ENABLE_JUMP=0 with opcode 000010 -> same.
- CNT_W=4, 16 consecutive j instructions -> instret counts 1..15 then wraps to 0; each j asserts PCSrc=10, PCEn=1 in JUMP.

Source files
------------

// File: rtl/mc_controlunit.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction over 3-5 cycles.
// Drives datapath selects, write strobes, ALU control, an illegal-instruction pulse and a retired counter.
module mc_controlunit #(
  parameter int ENABLE_ADDI = 1,
  parameter int ENABLE_JUMP = 1,
  parameter int ENABLE_BNE  = 0,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             Zero,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic [2:0]       alucontrol,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       fsm_state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state, next_state;
  state_t decode_next;
  logic   decode_ill;
  logic   funct_ok;
  logic   retire;
  logic   pc_write, branch, is_bne;
  logic   mem_write_d, ir_write_d, reg_write_d;

  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  // Disabled optional opcodes fall through to the illegal path.
  always_comb begin
    decode_next = S_FETCH;
    decode_ill  = 1'b1;
    case (opcode)
      OP_LW, OP_SW: begin
        decode_next = S_MEMADR;
        decode_ill  = 1'b0;
      end
      OP_R: if (funct_ok) begin
        decode_next = S_EXECUTE;
        decode_ill  = 1'b0;
      end
      OP_BEQ: begin
        decode_next = S_BRANCH;
        decode_ill  = 1'b0;
      end
      OP_BNE: if (ENABLE_BNE != 0) begin
        decode_next = S_BRANCH;
        decode_ill  = 1'b0;
      end
      OP_ADDI: if (ENABLE_ADDI != 0) begin
        decode_next = S_ADDIEX;
        decode_ill  = 1'b0;
      end
      OP_J: if (ENABLE_JUMP != 0) begin
        decode_next = S_JUMP;
        decode_ill  = 1'b0;
      end
      default: begin
        decode_next = S_FETCH;
        decode_ill  = 1'b1;
      end
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = S_DECODE;
      S_DECODE:  next_state = decode_next;
      S_MEMADR:  next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = S_MEMWB;
      S_EXECUTE: next_state = S_ALUWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: next_state = S_FETCH;
      default:   next_state = S_FETCH;
    endcase
  end

  always_comb begin
    IorD        = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    reg_write_d = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    alucontrol  = 3'b000;
    pc_write    = 1'b0;
    branch      = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write_d = 1'b1;
        ALUSrcB    = 2'b01;
        alucontrol = 3'b010;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        alucontrol = 3'b010;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        alucontrol = 3'b010;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_d = 1'b1;
      end
      S_MEMWR: begin
        IorD        = 1'b1;
        mem_write_d = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      S_ALUWB: begin
        RegDst      = 1'b1;
        reg_write_d = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        alucontrol = 3'b110;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIWB: reg_write_d = 1'b1;
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked by reset so an abandoned instruction cannot write anything.
  assign is_bne   = (opcode == OP_BNE);
  assign MemWrite = mem_write_d & ~reset;
  assign IRWrite  = ir_write_d & ~reset;
  assign RegWrite = reg_write_d & ~reset;
  assign PCEn     = (pc_write | (branch & (Zero ^ is_bne))) & ~reset;

  assign retire = (state == S_MEMWB) || (state == S_MEMWR) || (state == S_ALUWB) ||
                  (state == S_BRANCH) || (state == S_ADDIWB) || (state == S_JUMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_instr <= 1'b0;
      instret       <= '0;
    end else begin
      illegal_instr <= (state == S_DECODE) && decode_ill;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_controlunit.sv
// Bench for mc_controlunit: three configurations driven in turn, per-cycle outputs
// compared against an instruction-level reference model through an expected queue.
module tb_mc_controlunit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst = 3'b111;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  int         sel = 0;
  bit         mon_en = 1'b0;

  logic       iord[3], mem_write[3], ir_write[3], reg_dst[3], mem_to_reg[3];
  logic       reg_write[3], src_a[3], pc_en[3], ill[3];
  logic [1:0] src_b[3], pc_src[3];
  logic [2:0] alu[3];
  logic [3:0] st[3];
  logic [31:0] inst0, inst1;
  logic [3:0]  inst2;
  logic [31:0] ret[3];
  logic [47:0] obs[3];

  // 0: default parameters, 1: bne on / j and addi off, 2: default with a 4-bit counter
  mc_controlunit dut0 (
    .clk(clk), .reset(rst[0]), .opcode(opcode), .funct(funct), .Zero(zero),
    .IorD(iord[0]), .MemWrite(mem_write[0]), .IRWrite(ir_write[0]), .RegDst(reg_dst[0]),
    .MemtoReg(mem_to_reg[0]), .RegWrite(reg_write[0]), .ALUSrcA(src_a[0]), .ALUSrcB(src_b[0]),
    .PCSrc(pc_src[0]), .PCEn(pc_en[0]), .alucontrol(alu[0]), .illegal_instr(ill[0]),
    .instret(inst0), .fsm_state(st[0]));

  mc_controlunit #(.ENABLE_ADDI(0), .ENABLE_JUMP(0), .ENABLE_BNE(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(rst[1]), .opcode(opcode), .funct(funct), .Zero(zero),
    .IorD(iord[1]), .MemWrite(mem_write[1]), .IRWrite(ir_write[1]), .RegDst(reg_dst[1]),
    .MemtoReg(mem_to_reg[1]), .RegWrite(reg_write[1]), .ALUSrcA(src_a[1]), .ALUSrcB(src_b[1]),
    .PCSrc(pc_src[1]), .PCEn(pc_en[1]), .alucontrol(alu[1]), .illegal_instr(ill[1]),
    .instret(inst1), .fsm_state(st[1]));

  mc_controlunit #(.CNT_W(4)) dut2 (
    .clk(clk), .reset(rst[2]), .opcode(opcode), .funct(funct), .Zero(zero),
    .IorD(iord[2]), .MemWrite(mem_write[2]), .IRWrite(ir_write[2]), .RegDst(reg_dst[2]),
    .MemtoReg(mem_to_reg[2]), .RegWrite(reg_write[2]), .ALUSrcA(src_a[2]), .ALUSrcB(src_b[2]),
    .PCSrc(pc_src[2]), .PCEn(pc_en[2]), .alucontrol(alu[2]), .illegal_instr(ill[2]),
    .instret(inst2), .fsm_state(st[2]));

  assign ret[0] = inst0;
  assign ret[1] = inst1;
  assign ret[2] = {28'd0, inst2};

  for (genvar g = 0; g < 3; g++) begin : g_pack
    assign obs[g] = {ret[g], iord[g], mem_write[g], ir_write[g], reg_dst[g], mem_to_reg[g],
                     reg_write[g], src_a[g], src_b[g], pc_src[g], pc_en[g], alu[g], ill[g]};
  end

  logic [47:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_instret;
  bit m_ill;

  function automatic bit en_bne(int s);  return s == 1; endfunction
  function automatic bit en_jump(int s); return s != 1; endfunction
  function automatic bit en_addi(int s); return s != 1; endfunction
  function automatic logic [31:0] wrap(logic [31:0] v, int s);
    return (s == 2) ? (v & 32'h0000_000F) : v;
  endfunction

  // flags order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
  function automatic logic [15:0] ov(logic [6:0] flags, logic [1:0] sb, logic [1:0] ps,
                                     logic pcen, logic [2:0] a);
    return {flags, sb, ps, pcen, a, 1'b0};
  endfunction

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", name, sel, $time, got, exp);
    end
  endtask

  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cycle_unexpected dut%0d t=%0t got=%h expected=none", sel, $time, obs[sel]);
        end else begin
          e = exp_q.pop_front();
          check("cycle", obs[sel], e);
        end
      end
    end
  end

  // Issue one instruction starting in a FETCH cycle; cut truncates it after that many cycles.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int cut);
    logic [15:0] seq[$];
    logic [15:0] v;
    logic [2:0]  a;
    bit retires, fn_ok;
    int n;
    retires = 1'b1;
    fn_ok = 1'b1;
    case (fn)
      6'b100000: a = 3'b010;
      6'b100010: a = 3'b110;
      6'b100100: a = 3'b000;
      6'b100101: a = 3'b001;
      6'b101010: a = 3'b111;
      default: begin a = 3'b010; fn_ok = 1'b0; end
    endcase
    seq.push_back(ov(7'b0010000, 2'b01, 2'b00, 1'b1, 3'b010));
    seq.push_back(ov(7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010));
    if (op == 6'b100011) begin
      seq.push_back(ov(7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010));
      seq.push_back(ov(7'b1000000, 2'b00, 2'b00, 1'b0, 3'b000));
      seq.push_back(ov(7'b0000110, 2'b00, 2'b00, 1'b0, 3'b000));
    end else if (op == 6'b101011) begin
      seq.push_back(ov(7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010));
      seq.push_back(ov(7'b1100000, 2'b00, 2'b00, 1'b0, 3'b000));
    end else if (op == 6'b000000 && fn_ok) begin
      seq.push_back(ov(7'b0000001, 2'b00, 2'b00, 1'b0, a));
      seq.push_back(ov(7'b0001010, 2'b00, 2'b00, 1'b0, 3'b000));
    end else if (op == 6'b000100 || (op == 6'b000101 && en_bne(sel))) begin
      seq.push_back(ov(7'b0000001, 2'b00, 2'b01, (op == 6'b000101) ? ~z : z, 3'b110));
    end else if (op == 6'b001000 && en_addi(sel)) begin
      seq.push_back(ov(7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010));
      seq.push_back(ov(7'b0000010, 2'b00, 2'b00, 1'b0, 3'b000));
    end else if (op == 6'b000010 && en_jump(sel)) begin
      seq.push_back(ov(7'b0000000, 2'b00, 2'b10, 1'b1, 3'b000));
    end else begin
      retires = 1'b0;
    end
    opcode = op;
    funct = fn;
    zero = z;
    n = (cut < seq.size()) ? cut : seq.size();
    for (int i = 0; i < n; i++) begin
      v = seq[i];
      if (i == 0) v[0] = m_ill;
      exp_q.push_back({wrap(m_instret, sel), v});
    end
    m_ill = 1'b0;
    if (n == seq.size()) begin
      if (retires) m_instret = m_instret + 32'd1;
      else m_ill = 1'b1;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_phase(input int s);
    mon_en = 1'b0;
    rst = 3'b111;
    sel = s;
    @(posedge clk);
    #1;
    check("reset_state", obs[s], {32'd0, ov(7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010)});
    rst[s] = 1'b0;
    m_instret = 32'd0;
    m_ill = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic rand_instr(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [5:0] op, fn;
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2, 3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b000101;
        6: op = 6'b001000;
        7: op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      k = $urandom_range(0, 6);
      case (k)
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100100;
        3: fn = 6'b100101;
        4: fn = 6'b101010;
        default: fn = 6'($urandom);
      endcase
      issue(op, fn, 1'($urandom), 99);
    end
  endtask

  initial begin
    logic [5:0] functs[5];
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    start_phase(0);
    issue(6'b100011, 6'd0, 1'b0, 99);
    issue(6'b101011, 6'd0, 1'b0, 99);
    for (int i = 0; i < 5; i++) issue(6'b000000, functs[i], 1'b0, 99);
    issue(6'b000000, 6'b000000, 1'b0, 99);
    issue(6'b000100, 6'd0, 1'b1, 99);
    issue(6'b000100, 6'd0, 1'b0, 99);
    issue(6'b000101, 6'd0, 1'b0, 99);
    issue(6'b000010, 6'd0, 1'b0, 99);
    issue(6'b001000, 6'd0, 1'b0, 99);
    rand_instr(30);

    // lw abandoned in MEMRD by an asynchronous reset
    issue(6'b100011, 6'd0, 1'b0, 3);
    mon_en = 1'b0;
    #1 rst[0] = 1'b1;
    #1 check("reset_async", obs[0], {32'd0, ov(7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010)});
    @(posedge clk);
    #1 check("reset_hold", obs[0], {32'd0, ov(7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010)});
    rst[0] = 1'b0;
    m_instret = 32'd0;
    m_ill = 1'b0;
    mon_en = 1'b1;
    issue(6'b101011, 6'd0, 1'b0, 99);
    rand_instr(10);

    start_phase(1);
    issue(6'b000101, 6'd0, 1'b0, 99);
    issue(6'b000101, 6'd0, 1'b1, 99);
    issue(6'b000010, 6'd0, 1'b0, 99);
    issue(6'b001000, 6'd0, 1'b0, 99);
    issue(6'b000100, 6'd0, 1'b1, 99);
    rand_instr(30);

    start_phase(2);
    for (int i = 0; i < 17; i++) issue(6'b000010, 6'd0, 1'b0, 99);
    rand_instr(20);

    mon_en = 1'b0;
    check("queue_drained", 48'(exp_q.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
